fb_scanout_reader: RTL
======================

// Module: fb_scanout_reader
// PURPOSE
//  Framebuffer read-side counterpart of the rasterizer's pixel writes. Walks the
//  H_RES x V_RES frame in raster order, fetches each 32-bit pixel word over a
//  read-only master port and delivers a {sof,eol,RGB 10:10:10} valid/ready
//  stream to the display/output stage through an internal prefetch FIFO.
// PARAMETERS
//  H_RES       800            pixels per line
//  V_RES       600            lines per frame
//  FB_BASE     30'h32000000   address of pixel (0,0)
//  FIFO_DEPTH  16             prefetch entries (power of 2, >=2)
// PORTS
//  pll_clock                     in   1   sole clock, all logic rising-edge
//  sys_reset_n                   in   1   asynchronous, active-low reset
//  scan_enable                   in   1   level; start/continue frames
//  scan_mem_address              out  30  read address
//  scan_mem_byte_enable          out  4   4'hF while read=1, else 4'h0
//  scan_mem_read                 out  1   read request, held until ack
//  scan_mem_write                out  1   constant 0
//  scan_mem_write_data           out  32  constant 0
//  scan_mem_acknowledge          in   1   read completes this cycle
//  scan_mem_read_data            in   32  bits[29:0]=R[29:20],G[19:10],B[9:0]
//  pix_valid                     out  1   FIFO non-empty (first-word fall-through)
//  pix_data                      out  30  RGB of head entry
//  pix_sof / pix_eol             out  1   head is pixel (0,0) / x==H_RES-1
//  pix_ready                     in   1   consumer accepts when valid&ready
//  frame_done                    out  1   1-cycle pulse: last pixel of frame popped
//  scan_busy                     out  1   1 from first request to last fetch ack
// BEHAVIOUR
//  Reset (async, any state): all outputs 0; x=y=0; FIFO emptied; state IDLE;
//   an in-flight read is abandoned and a late ack is ignored.
//  Address = FB_BASE + ((y*H_RES + x) << 2), truncated to 30 bits.
//  FSM:
//   IDLE: when scan_enable=1 and FIFO count<FIFO_DEPTH -> REQ, busy=1.
//   REQ:  read=1, address/byte_enable stable until ack. On ack: push
//         {x==0&&y==0, x==H_RES-1, read_data[29:0]}; read=0 same edge; advance
//         x (wrap to 0 at H_RES-1 with y+1). Last pixel (H_RES-1,V_RES-1) ->
//         x=y=0, busy=0, -> IDLE. Else -> GAP.
//   GAP:  1 cycle, read=0; -> REQ if count<FIFO_DEPTH, else stay in GAP.
//  At most one outstanding read; space is checked before request, so ack
//   never meets a full FIFO. Ack while read=0 is ignored.
//  scan_enable is sampled only in IDLE: deassertion mid-frame finishes the
//   frame; held high gives back-to-back frames starting in (0,0) again.
//  Latency: enable high in IDLE -> read=1 next cycle; ack cycle N -> entry
//   visible on pix_valid in cycle N+1.
//  FIFO: simultaneous push+pop keeps count; pop when empty impossible (pop
//   only on valid&ready); pix_* hold while valid&!ready.
//  frame_done pulses the cycle after the pop of the entry with eol at y=V_RES-1.
//  Counters x,y sized $clog2(H_RES), $clog2(V_RES); address multiply at 30 bits.
// TESTING
//  T1 reset: assert sys_reset_n=0 mid-REQ -> read,pix_valid,busy=0 at once;
//     after release with enable=0 no read issued for 100 cycles.
//  T2 addressing: H_RES=4,V_RES=2, ack 1 cycle after each read -> addresses
//     0x32000000,..04,..08,..0C,..10..1C, 8 reads, then IDLE.
//  T3 data/markers: read_data=32'hFFF00000|i, pix_ready=1 -> pix_data=
//     30'h3FF00000|i; sof only on i=0; eol on i=3,7; frame_done once.
//  T4 backpressure: pix_ready=0, DEPTH=16 -> exactly 16 reads then read stays
//     0; raise pix_ready -> fetching resumes, no pixel lost or duplicated.
//  T5 slow memory: ack delayed 0..7 random cycles -> address/byte_enable stable
//     while read=1; stream order matches addresses 0..N-1.
//  T6 enable: drop scan_enable after 3rd read -> frame completes (8 pixels),
//     no further reads; hold high -> second frame restarts at FB_BASE.

Source files
------------

// File: rtl/fb_scanout_reader.sv
// Raster-order framebuffer scan-out: fetches one 32-bit pixel word per read and
// streams {sof, eol, RGB 10:10:10} to the display stage through a prefetch FIFO.
module fb_scanout_reader #(
  parameter int          H_RES      = 800,
  parameter int          V_RES      = 600,
  parameter logic [29:0] FB_BASE    = 30'h32000000,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        pll_clock,
  input  logic        sys_reset_n,
  input  logic        scan_enable,
  output logic [29:0] scan_mem_address,
  output logic [3:0]  scan_mem_byte_enable,
  output logic        scan_mem_read,
  output logic        scan_mem_write,
  output logic [31:0] scan_mem_write_data,
  input  logic        scan_mem_acknowledge,
  input  logic [31:0] scan_mem_read_data,
  output logic        pix_valid,
  output logic [29:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  input  logic        pix_ready,
  output logic        frame_done,
  output logic        scan_busy
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t          state_reg, state_next;
  logic [XW-1:0]   x_reg, x_next;
  logic [YW-1:0]   y_reg, y_next;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            frame_done_reg;
  logic [32:0]     mem [FIFO_DEPTH];

  logic            last_x, last_y, space, push, pop;
  logic [29:0]     pix_index, fetch_address;
  logic [32:0]     entry, head;
  logic            unused_rd_bits;

  assign unused_rd_bits = ^scan_mem_read_data[31:30];

  assign last_x = (x_reg == XW'(H_RES - 1));
  assign last_y = (y_reg == YW'(V_RES - 1));
  assign space  = (count_reg < CW'(FIFO_DEPTH));
  assign push   = (state_reg == REQ) && scan_mem_acknowledge;
  assign pop    = pix_valid && pix_ready;

  assign pix_index     = 30'(y_reg) * 30'(H_RES) + 30'(x_reg);
  assign fetch_address = FB_BASE + (pix_index << 2);

  // Read strobe and qualifiers decode straight from the state register so an
  // asynchronous reset drops them immediately, abandoning any in-flight read.
  assign scan_mem_read        = (state_reg == REQ);
  assign scan_mem_address     = scan_mem_read ? fetch_address : 30'h0;
  assign scan_mem_byte_enable = scan_mem_read ? 4'hF : 4'h0;
  assign scan_mem_write       = 1'b0;
  assign scan_mem_write_data  = 32'h0;
  assign scan_busy            = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    case (state_reg)
      IDLE: if (scan_enable && space) state_next = REQ;
      REQ: begin
        if (scan_mem_acknowledge) begin
          state_next = GAP;
          if (last_x) begin
            x_next = '0;
            if (last_y) begin
              y_next     = '0;
              state_next = IDLE;
            end else begin
              y_next = y_reg + YW'(1);
            end
          end else begin
            x_next = x_reg + XW'(1);
          end
        end
      end
      GAP:     if (space) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pll_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
    end
  end

  // Entry layout: {last pixel of frame, sof, eol, rgb}
  assign entry = {last_x && last_y, (x_reg == '0) && (y_reg == '0), last_x,
                  scan_mem_read_data[29:0]};

  always_ff @(posedge pll_clock) begin
    if (push) mem[wr_ptr_reg] <= entry;
  end

  always_ff @(posedge pll_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      frame_done_reg <= pop && head[32];
    end
  end

  assign head       = mem[rd_ptr_reg];
  assign pix_valid  = (count_reg != '0);
  assign pix_data   = pix_valid ? head[29:0] : 30'h0;
  assign pix_eol    = pix_valid && head[30];
  assign pix_sof    = pix_valid && head[31];
  assign frame_done = frame_done_reg;

endmodule
